// File: rtl/atm_pkg.sv
// Shared encodings for the ATM account server: opcodes, response statuses,
// FSM states and the width of the per-account bad-PIN counter.
package atm_pkg;

    // Transaction opcodes (000 and 111 are deliberately unused)
    localparam logic [2:0] OP_BAL     = 3'b001;
    localparam logic [2:0] OP_DEP     = 3'b010;
    localparam logic [2:0] OP_WDR     = 3'b011;
    localparam logic [2:0] OP_XFER    = 3'b100;
    localparam logic [2:0] OP_PIN_CHG = 3'b101;
    localparam logic [2:0] OP_VERIFY  = 3'b110;

    // Response status codes
    localparam logic [2:0] STS_OK       = 3'b000;
    localparam logic [2:0] STS_BAD_PIN  = 3'b001;
    localparam logic [2:0] STS_NO_ACCT  = 3'b010;
    localparam logic [2:0] STS_INSUFF   = 3'b011;
    localparam logic [2:0] STS_LOCKED   = 3'b100;
    localparam logic [2:0] STS_OVERFLOW = 3'b101;
    localparam logic [2:0] STS_BAD_OP   = 3'b110;

    // Request processing pipeline, one request in flight at a time
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_CHECK  = 3'd2,
        S_EXEC   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Consecutive bad PINs that lock an account
    localparam int ATM_MAX_FAIL = 3;

    // Counter width able to hold 0..max_fail
    function automatic int cnt_width(input int max_fail);
        return (max_fail < 1) ? 1 : $clog2(max_fail + 1);
    endfunction

    localparam int FAIL_CNT_W = cnt_width(ATM_MAX_FAIL);

    // True for the six defined opcodes
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op == OP_BAL) || (op == OP_DEP) || (op == OP_WDR) ||
               (op == OP_XFER) || (op == OP_PIN_CHG) || (op == OP_VERIFY);
    endfunction

endpackage

// File: rtl/atm_acct_lookup.sv
// Combinational account-number match: compares one account number against
// every entry of the table and returns a hit flag and the matching index.
module atm_acct_lookup import atm_pkg::*; #(
    parameter int NUM_ACCTS = 4,
    parameter int ACCT_W    = 17,
    parameter int IDX_W     = 2
) (
    input  logic [ACCT_W-1:0]                 i_acct,
    input  logic [NUM_ACCTS-1:0][ACCT_W-1:0]  i_table,
    output logic                              o_hit,
    output logic [IDX_W-1:0]                  o_idx
);

    logic [NUM_ACCTS-1:0] w_match;

    for (genvar gi = 0; gi < NUM_ACCTS; gi++) begin : g_match
        assign w_match[gi] = (i_table[gi] == i_acct);
    end

    // Encode the match vector; numbers are unique, lowest index wins anyway
    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        for (int i = NUM_ACCTS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/atm_account_server.sv
// Bank-side account server: accepts one request at a time, looks up the
// source/destination accounts, authenticates the PIN, applies the
// transaction to a flop-based account table and returns status + balance.
module atm_account_server import atm_pkg::*; #(
    parameter int               NUM_ACCTS = 4,
    parameter int               ACCT_W    = 17,
    parameter int               PIN_W     = 17,
    parameter int               AMT_W     = 19,
    parameter logic [ACCT_W-1:0] ACCT_BASE = 17'h00100,
    parameter logic [PIN_W-1:0]  PIN_BASE  = 17'h01234,
    parameter logic [AMT_W-1:0]  INIT_BAL  = 19'd1000,
    parameter int               MAX_FAIL  = ATM_MAX_FAIL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_opcode,
    input  logic [ACCT_W-1:0] req_account,
    input  logic [PIN_W-1:0]  req_pin,
    input  logic [PIN_W-1:0]  req_new_pin,
    input  logic [ACCT_W-1:0] req_dest,
    input  logic [AMT_W-1:0]  req_amount,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_status,
    output logic [AMT_W-1:0]  rsp_balance
);

    localparam int IDX_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
    localparam int CNT_W = (cnt_width(MAX_FAIL) > FAIL_CNT_W) ? cnt_width(MAX_FAIL) : FAIL_CNT_W;

    // FSM state and registered outputs
    state_t             r_state;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [2:0]         r_rsp_status;
    logic [AMT_W-1:0]   r_rsp_balance;

    // Captured request
    logic [2:0]         r_req_op;
    logic [ACCT_W-1:0]  r_req_acct;
    logic [ACCT_W-1:0]  r_req_dest;
    logic [PIN_W-1:0]   r_req_pin;
    logic [PIN_W-1:0]   r_req_new_pin;
    logic [AMT_W-1:0]   r_req_amt;

    // Lookup results
    logic               r_src_hit;
    logic               r_dst_hit;
    logic [IDX_W-1:0]   r_src_idx;
    logic [IDX_W-1:0]   r_dst_idx;

    // Decision results
    logic [2:0]         r_status;
    logic [AMT_W-1:0]   r_new_src;
    logic [AMT_W-1:0]   r_new_dst;
    logic               r_pin_checked;
    logic               r_pin_bad;
    logic               r_same;

    // Table views and combinational decision
    logic [NUM_ACCTS-1:0][ACCT_W-1:0] w_acct_tbl;
    logic [AMT_W-1:0]   w_bal  [NUM_ACCTS];
    logic [PIN_W-1:0]   w_pin  [NUM_ACCTS];
    logic               w_lock [NUM_ACCTS];
    logic               w_src_hit;
    logic               w_dst_hit;
    logic [IDX_W-1:0]   w_src_idx;
    logic [IDX_W-1:0]   w_dst_idx;
    logic [AMT_W-1:0]   w_src_bal;
    logic [AMT_W-1:0]   w_dst_bal;
    logic [AMT_W:0]     w_src_sum;
    logic [AMT_W:0]     w_src_diff;
    logic [AMT_W:0]     w_dst_sum;
    logic [2:0]         w_status;
    logic [AMT_W-1:0]   w_new_src;
    logic [AMT_W-1:0]   w_new_dst;
    logic               w_pin_checked;
    logic               w_pin_bad;
    logic               w_same;
    logic               w_exec;

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_status  = r_rsp_status;
    assign rsp_balance = r_rsp_balance;
    assign w_exec      = (r_state == S_EXEC);

    // Account table: numbers are fixed, the rest reloads on reset
    for (genvar gi = 0; gi < NUM_ACCTS; gi++) begin : g_acct
        logic [AMT_W-1:0] r_bal;
        logic [PIN_W-1:0] r_pin_val;
        logic [CNT_W-1:0] r_fail_cnt;
        logic             r_locked;
        logic             w_src_sel;
        logic             w_dst_sel;

        assign w_acct_tbl[gi] = ACCT_W'(ACCT_BASE + ACCT_W'(gi));
        assign w_src_sel      = (r_src_idx == IDX_W'(gi));
        assign w_dst_sel      = (r_dst_idx == IDX_W'(gi));
        assign w_bal[gi]      = r_bal;
        assign w_pin[gi]      = r_pin_val;
        assign w_lock[gi]     = r_locked;

        // Apply the decided transaction and PIN bookkeeping in EXEC
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_bal      <= INIT_BAL;
                r_pin_val  <= PIN_W'(PIN_BASE + PIN_W'(gi));
                r_fail_cnt <= '0;
                r_locked   <= 1'b0;
            end else if (w_exec) begin
                if (r_status == STS_OK && w_src_sel) begin
                    r_bal <= r_new_src;
                    if (r_req_op == OP_PIN_CHG) begin
                        r_pin_val <= r_req_new_pin;
                    end
                end
                // Destination credit; src==dst was already turned into a no-op
                if (r_status == STS_OK && r_req_op == OP_XFER && !r_same && w_dst_sel) begin
                    r_bal <= r_new_dst;
                end
                if (r_pin_checked && w_src_sel) begin
                    if (r_pin_bad) begin
                        if (r_fail_cnt >= CNT_W'(MAX_FAIL - 1)) begin
                            r_locked <= 1'b1;
                        end
                        if (r_fail_cnt != CNT_W'(MAX_FAIL)) begin
                            r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_fail_cnt <= '0;
                    end
                end
            end
        end
    end

    atm_acct_lookup #(
        .NUM_ACCTS (NUM_ACCTS),
        .ACCT_W    (ACCT_W),
        .IDX_W     (IDX_W)
    ) u_src_lookup (
        .i_acct  (r_req_acct),
        .i_table (w_acct_tbl),
        .o_hit   (w_src_hit),
        .o_idx   (w_src_idx)
    );

    atm_acct_lookup #(
        .NUM_ACCTS (NUM_ACCTS),
        .ACCT_W    (ACCT_W),
        .IDX_W     (IDX_W)
    ) u_dst_lookup (
        .i_acct  (r_req_dest),
        .i_table (w_acct_tbl),
        .o_hit   (w_dst_hit),
        .o_idx   (w_dst_idx)
    );

    assign w_src_bal  = w_bal[r_src_idx];
    assign w_dst_bal  = w_bal[r_dst_idx];
    assign w_src_sum  = {1'b0, w_src_bal} + {1'b0, r_req_amt};
    assign w_src_diff = {1'b0, w_src_bal} - {1'b0, r_req_amt};
    assign w_dst_sum  = {1'b0, w_dst_bal} + {1'b0, r_req_amt};
    assign w_same     = (r_src_idx == r_dst_idx);

    // Status decision in priority order, plus the post-op balances
    always_comb begin
        w_status      = STS_OK;
        w_new_src     = w_src_bal;
        w_new_dst     = w_dst_bal;
        w_pin_checked = 1'b0;
        w_pin_bad     = 1'b0;
        if (!op_is_valid(r_req_op)) begin
            w_status = STS_BAD_OP;
        end else if (!r_src_hit) begin
            w_status = STS_NO_ACCT;
        end else if (w_lock[r_src_idx]) begin
            w_status = STS_LOCKED;
        end else begin
            w_pin_checked = 1'b1;
            if (r_req_pin != w_pin[r_src_idx]) begin
                w_pin_bad = 1'b1;
                w_status  = STS_BAD_PIN;
            end else begin
                case (r_req_op)
                    OP_DEP: begin
                        if (w_src_sum[AMT_W]) w_status  = STS_OVERFLOW;
                        else                  w_new_src = w_src_sum[AMT_W-1:0];
                    end
                    OP_WDR: begin
                        if (w_src_diff[AMT_W]) w_status  = STS_INSUFF;
                        else                   w_new_src = w_src_diff[AMT_W-1:0];
                    end
                    OP_XFER: begin
                        if (!r_dst_hit) begin
                            w_status = STS_NO_ACCT;
                        end else if (!w_same) begin
                            if (w_src_diff[AMT_W]) begin
                                w_status = STS_INSUFF;
                            end else if (w_dst_sum[AMT_W]) begin
                                w_status = STS_OVERFLOW;
                            end else begin
                                w_new_src = w_src_diff[AMT_W-1:0];
                                w_new_dst = w_dst_sum[AMT_W-1:0];
                            end
                        end
                    end
                    OP_BAL, OP_PIN_CHG, OP_VERIFY: begin
                        w_new_src = w_src_bal;
                    end
                    default: begin
                        w_new_src = w_src_bal;
                    end
                endcase
            end
        end
    end

    // Request FSM: capture, lookup, check, execute, respond
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= STS_OK;
            r_rsp_balance <= '0;
            r_req_op      <= '0;
            r_req_acct    <= '0;
            r_req_dest    <= '0;
            r_req_pin     <= '0;
            r_req_new_pin <= '0;
            r_req_amt     <= '0;
            r_src_hit     <= 1'b0;
            r_dst_hit     <= 1'b0;
            r_src_idx     <= '0;
            r_dst_idx     <= '0;
            r_status      <= STS_OK;
            r_new_src     <= '0;
            r_new_dst     <= '0;
            r_pin_checked <= 1'b0;
            r_pin_bad     <= 1'b0;
            r_same        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_op      <= req_opcode;
                        r_req_acct    <= req_account;
                        r_req_dest    <= req_dest;
                        r_req_pin     <= req_pin;
                        r_req_new_pin <= req_new_pin;
                        r_req_amt     <= req_amount;
                        r_req_ready   <= 1'b0;
                        r_state       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_src_hit <= w_src_hit;
                    r_src_idx <= w_src_idx;
                    r_dst_hit <= w_dst_hit;
                    r_dst_idx <= w_dst_idx;
                    r_state   <= S_CHECK;
                end
                S_CHECK: begin
                    r_status      <= w_status;
                    r_new_src     <= w_new_src;
                    r_new_dst     <= w_new_dst;
                    r_pin_checked <= w_pin_checked;
                    r_pin_bad     <= w_pin_bad;
                    r_same        <= w_same;
                    r_state       <= S_EXEC;
                end
                S_EXEC: begin
                    r_rsp_status  <= r_status;
                    r_rsp_balance <= (r_status == STS_OK) ? r_new_src : '0;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_account_server.sv
// Self-checking bench for atm_account_server: a table of request vectors
// with expected status/balance, a response scoreboard, and hand-written
// sequences for response back-pressure and reset in mid-transaction.
module tb_atm_account_server;

    localparam logic [2:0] BAL  = 3'b001;
    localparam logic [2:0] DEP  = 3'b010;
    localparam logic [2:0] WDR  = 3'b011;
    localparam logic [2:0] XFER = 3'b100;
    localparam logic [2:0] PCHG = 3'b101;
    localparam logic [2:0] VER  = 3'b110;
    localparam logic [2:0] OP0  = 3'b000;
    localparam logic [2:0] OP7  = 3'b111;

    localparam logic [2:0] OK   = 3'd0;
    localparam logic [2:0] BPIN = 3'd1;
    localparam logic [2:0] NOAC = 3'd2;
    localparam logic [2:0] INSF = 3'd3;
    localparam logic [2:0] LOCK = 3'd4;
    localparam logic [2:0] OVF  = 3'd5;
    localparam logic [2:0] BOP  = 3'd6;

    localparam int NV = 29;

    typedef struct {
        bit          rst;
        logic [2:0]  op;
        logic [16:0] acct;
        logic [16:0] pin;
        logic [16:0] new_pin;
        logic [16:0] dest;
        logic [18:0] amt;
        logic [2:0]  st;
        logic [18:0] bal;
    } vec_t;

    typedef struct {
        logic [2:0]  st;
        logic [18:0] bal;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_opcode;
    logic [16:0] req_account;
    logic [16:0] req_pin;
    logic [16:0] req_new_pin;
    logic [16:0] req_dest;
    logic [18:0] req_amount;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_status;
    logic [18:0] rsp_balance;

    exp_t sb_q[$];
    vec_t vecs[NV];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    atm_account_server dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_account (req_account),
        .req_pin     (req_pin),
        .req_new_pin (req_new_pin),
        .req_dest    (req_dest),
        .req_amount  (req_amount),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input bit rst, input logic [2:0] op, input logic [16:0] acct,
                                input logic [16:0] pin, input logic [16:0] dest,
                                input logic [18:0] amt, input logic [2:0] st,
                                input logic [18:0] bal);
        vec_t v;
        v.rst = rst; v.op = op; v.acct = acct; v.pin = pin; v.new_pin = 17'h0;
        v.dest = dest; v.amt = amt; v.st = st; v.bal = bal;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issue one request, score the response, optionally back-pressure it
    task automatic run_txn(input vec_t v, input int hold);
        int   guard;
        int   lat;
        exp_t e;
        exp_t got;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        if (req_ready === 1'b1) begin
            req_opcode  = v.op;
            req_account = v.acct;
            req_pin     = v.pin;
            req_new_pin = v.new_pin;
            req_dest    = v.dest;
            req_amount  = v.amt;
            req_valid   = 1'b1;
            e.st  = v.st;
            e.bal = v.bal;
            sb_q.push_back(e);
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("ready_low_in_flight", 32'(req_ready), 32'd0);
            lat = 0;
            while (rsp_valid !== 1'b1 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            check("rsp_latency", 32'(lat), 32'd3);
            if (rsp_valid === 1'b1) begin
                got.st  = rsp_status;
                got.bal = rsp_balance;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: got a response, expected none pending");
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_status", 32'(got.st), 32'(e.st));
                    check("rsp_balance", 32'(got.bal), 32'(e.bal));
                end
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    check("hold_valid", 32'(rsp_valid), 32'd1);
                    check("hold_status", 32'(rsp_status), 32'(e.st));
                    check("hold_balance", 32'(rsp_balance), 32'(e.bal));
                    check("hold_req_ready", 32'(req_ready), 32'd0);
                end
                rsp_ready = 1'b1;
                @(posedge clk); #1;
                rsp_ready = 1'b0;
                check("valid_drop", 32'(rsp_valid), 32'd0);
                check("ready_back", 32'(req_ready), 32'd1);
                $display("txn %0d op=%0d acct=0x%0h status=%0d bal=%0d", n_txn, v.op, v.acct,
                         got.st, got.bal);
            end else begin
                if (sb_q.size() != 0) e = sb_q.pop_front();
                $display("txn %0d op=%0d acct=0x%0h no response", n_txn, v.op, v.acct);
            end
        end
        n_txn++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "time limit reached");
    end

    initial begin
        vec_t v;
        reset       = 1'b0;
        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        req_opcode  = 3'd0;
        req_account = 17'h0;
        req_pin     = 17'h0;
        req_new_pin = 17'h0;
        req_dest    = 17'h0;
        req_amount  = 19'd0;

        //            rst op    acct       pin        dest       amt           status bal
        vecs[0]  = mk(0, BAL,  17'h00100, 17'h01234, 17'h00000, 19'd0,      OK,   19'd1000);
        vecs[1]  = mk(0, WDR,  17'h00100, 17'h01234, 17'h00000, 19'd1001,   INSF, 19'd0);
        vecs[2]  = mk(0, WDR,  17'h00100, 17'h01234, 17'h00000, 19'd1000,   OK,   19'd0);
        vecs[3]  = mk(0, BAL,  17'h00100, 17'h01234, 17'h00000, 19'd0,      OK,   19'd0);
        vecs[4]  = mk(0, BAL,  17'h00101, 17'h00000, 17'h00000, 19'd0,      BPIN, 19'd0);
        vecs[5]  = mk(0, BAL,  17'h00101, 17'h00000, 17'h00000, 19'd0,      BPIN, 19'd0);
        vecs[6]  = mk(0, BAL,  17'h00101, 17'h00000, 17'h00000, 19'd0,      BPIN, 19'd0);
        vecs[7]  = mk(0, BAL,  17'h00101, 17'h01235, 17'h00000, 19'd0,      LOCK, 19'd0);
        vecs[8]  = mk(1, BAL,  17'h00101, 17'h01235, 17'h00000, 19'd0,      OK,   19'd1000);
        vecs[9]  = mk(0, XFER, 17'h00102, 17'h01236, 17'h00103, 19'd300,    OK,   19'd700);
        vecs[10] = mk(0, BAL,  17'h00103, 17'h01237, 17'h00000, 19'd0,      OK,   19'd1300);
        vecs[11] = mk(0, XFER, 17'h00102, 17'h01236, 17'h001FF, 19'd1,      NOAC, 19'd0);
        vecs[12] = mk(0, OP7,  17'h00100, 17'h01234, 17'h00000, 19'd0,      BOP,  19'd0);
        vecs[13] = mk(0, OP0,  17'h00100, 17'h01234, 17'h00000, 19'd0,      BOP,  19'd0);
        vecs[14] = mk(1, DEP,  17'h00103, 17'h01237, 17'h00000, 19'd523287, OK,   19'd524287);
        vecs[15] = mk(0, DEP,  17'h00103, 17'h01237, 17'h00000, 19'd1,      OVF,  19'd0);
        vecs[16] = mk(0, DEP,  17'h00103, 17'h01237, 17'h00000, 19'd0,      OK,   19'd524287);
        vecs[17] = mk(0, XFER, 17'h00102, 17'h01236, 17'h00103, 19'd1,      OVF,  19'd0);
        vecs[18] = mk(0, XFER, 17'h00102, 17'h01236, 17'h00102, 19'd5000,   OK,   19'd1000);
        vecs[19] = mk(0, XFER, 17'h00102, 17'h01236, 17'h00100, 19'd1001,   INSF, 19'd0);
        vecs[20] = mk(0, BAL,  17'h00104, 17'h01238, 17'h00000, 19'd0,      NOAC, 19'd0);
        vecs[21] = mk(0, VER,  17'h00100, 17'h01234, 17'h00000, 19'd0,      OK,   19'd1000);
        vecs[22] = mk(0, OP0,  17'h001FF, 17'h01234, 17'h00000, 19'd0,      BOP,  19'd0);
        vecs[23] = mk(0, XFER, 17'h00100, 17'h00000, 17'h001FF, 19'd0,      BPIN, 19'd0);
        vecs[24] = mk(0, BAL,  17'h00100, 17'h01234, 17'h00000, 19'd0,      OK,   19'd1000);
        vecs[25] = mk(0, BAL,  17'h00100, 17'h00000, 17'h00000, 19'd0,      BPIN, 19'd0);
        vecs[26] = mk(0, BAL,  17'h00100, 17'h00000, 17'h00000, 19'd0,      BPIN, 19'd0);
        vecs[27] = mk(0, BAL,  17'h00100, 17'h01234, 17'h00000, 19'd0,      OK,   19'd1000);
        vecs[28] = mk(0, WDR,  17'h00101, 17'h01235, 17'h00000, 19'd0,      OK,   19'd1000);

        // Reset state, sampled while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_status", 32'(rsp_status), 32'd0);
        check("reset_rsp_balance", 32'(rsp_balance), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) pulse_reset();
            run_txn(vecs[i], 0);
        end

        // Overflowing deposit with the response held for 5 cycles
        pulse_reset();
        run_txn(mk(0, DEP, 17'h00103, 17'h01237, 17'h00000, 19'd523288, OVF, 19'd0), 5);
        run_txn(mk(0, BAL, 17'h00103, 17'h01237, 17'h00000, 19'd0, OK, 19'd1000), 0);

        // PIN change, old PIN rejected, new PIN accepted
        v = mk(0, PCHG, 17'h00100, 17'h01234, 17'h00000, 19'd0, OK, 19'd1000);
        v.new_pin = 17'h0BEEF;
        run_txn(v, 0);
        run_txn(mk(0, BAL, 17'h00100, 17'h01234, 17'h00000, 19'd0, BPIN, 19'd0), 0);
        run_txn(mk(0, BAL, 17'h00100, 17'h0BEEF, 17'h00000, 19'd0, OK, 19'd1000), 0);
        run_txn(mk(0, WDR, 17'h00100, 17'h0BEEF, 17'h00000, 19'd100, OK, 19'd900), 0);

        // Reset while a request sits in CHECK: it must be dropped
        req_opcode  = BAL;
        req_account = 17'h00100;
        req_pin     = 17'h0BEEF;
        req_valid   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("dropped_no_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("txn %0d op=%0d acct=0x%0h dropped by reset", n_txn, BAL, 17'h00100);
        n_txn++;
        run_txn(mk(0, BAL, 17'h00100, 17'h01234, 17'h00000, 19'd0, OK, 19'd1000), 0);
        run_txn(mk(0, BAL, 17'h00100, 17'h0BEEF, 17'h00000, 19'd0, BPIN, 19'd0), 0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
